lsu_ctrl: RTL and testbench

Load/store unit that sits directly upstream of the word-addressed data memory and performs byte, halfword and word accesses on it for the core. Byte/halfword loads are extracted and extended. Byte/halfword stores are done as a two-access read-modify-write, because the memory only writes whole words. Misaligned or illegal accesses are rejected and never touch memory. A valid/ready request and one-cycle response pulse let the core stall while an access is in flight.

---
 rtl/lsu_ctrl_if.sv | 32 +++
 rtl/lsu_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// Core/memory-facing bundle of the load/store unit: request/response handshake
// plus the word-addressed data memory port.
interface lsu_ctrl_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [2:0]          req_funct3;
  logic [ADDR_LEN-1:0] req_addr;
  logic [DATA_LEN-1:0] req_wdata;
  logic                resp_valid;
  logic [DATA_LEN-1:0] resp_rdata;
  logic                resp_err;
  logic                mem_we;
  logic [ADDR_LEN-1:0] mem_addr;
  logic [DATA_LEN-1:0] mem_wdata;
  logic [DATA_LEN-1:0] mem_rdata;

  // Core and memory side of the unit
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );

  // The load/store unit itself
  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Byte/halfword/word load/store unit in front of a word-only data memory;
// sub-word stores are performed as read-modify-write.
module lsu_ctrl #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  state_t              state_r;
  logic                we_r;
  logic [2:0]          funct3_r;
  logic [1:0]          off_r;
  logic                req_ready_r;
  logic                resp_valid_r;
  logic [DATA_LEN-1:0] resp_rdata_r;
  logic                resp_err_r;
  logic                mem_we_r;
  logic [ADDR_LEN-1:0] mem_addr_r;
  logic [DATA_LEN-1:0] mem_wdata_r;
  logic                legal_s;

  function automatic logic [DATA_LEN-1:0] load_extract(
    input logic [2:0]          f3,
    input logic [1:0]          off,
    input logic [DATA_LEN-1:0] w
  );
    logic [7:0]          b;
    logic [15:0]         h;
    logic [DATA_LEN-1:0] r;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{(DATA_LEN-8){b[7]}}, b};
      F3_H:    r = {{(DATA_LEN-16){h[15]}}, h};
      F3_BU:   r = {{(DATA_LEN-8){1'b0}}, b};
      F3_HU:   r = {{(DATA_LEN-16){1'b0}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_LEN-1:0] store_merge(
    input logic [2:0]          f3,
    input logic [1:0]          off,
    input logic [DATA_LEN-1:0] w,
    input logic [15:0]         d
  );
    logic [DATA_LEN-1:0] r;
    r = w;
    if (f3 == F3_B) begin
      case (off)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (off[1]) begin
      r[31:16] = d;
    end else begin
      r[15:0] = d;
    end
    return r;
  endfunction

  // Legality of the request presented on the live inputs
  always_comb begin
    legal_s = 1'b0;
    case (bus.req_funct3)
      F3_B:    legal_s = 1'b1;
      F3_H:    legal_s = ~bus.req_addr[0];
      F3_W:    legal_s = (bus.req_addr[1:0] == 2'b00);
      F3_BU:   legal_s = ~bus.req_we;
      F3_HU:   legal_s = ~bus.req_we & ~bus.req_addr[0];
      default: legal_s = 1'b0;
    endcase
  end

  // Control FSM; every output is registered so reset clears mem_we asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      funct3_r     <= 3'b000;
      off_r        <= 2'b00;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= {DATA_LEN{1'b0}};
      resp_err_r   <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {ADDR_LEN{1'b0}};
      mem_wdata_r  <= {DATA_LEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            // mem_wdata_r doubles as the request's store-data register
            we_r         <= bus.req_we;
            funct3_r     <= bus.req_funct3;
            off_r        <= bus.req_addr[1:0];
            mem_addr_r   <= {bus.req_addr[ADDR_LEN-1:2], 2'b00};
            mem_wdata_r  <= (legal_s && bus.req_we) ? bus.req_wdata : {DATA_LEN{1'b0}};
            req_ready_r  <= 1'b0;
            resp_rdata_r <= {DATA_LEN{1'b0}};
            if (legal_s) begin
              mem_we_r   <= bus.req_we && (bus.req_funct3 == F3_W);
              resp_err_r <= 1'b0;
              state_r    <= ACCESS;
            end else begin
              mem_we_r     <= 1'b0;
              resp_err_r   <= 1'b1;
              resp_valid_r <= 1'b1;
              state_r      <= RESP;
            end
          end
        end
        ACCESS: begin
          mem_we_r <= 1'b0;
          if (!we_r) begin
            resp_rdata_r <= load_extract(funct3_r, off_r, bus.mem_rdata);
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end else if (funct3_r == F3_W) begin
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            mem_wdata_r <= store_merge(funct3_r, off_r, bus.mem_rdata, mem_wdata_r[15:0]);
            mem_we_r    <= 1'b1;
            state_r     <= WRITE;
          end
        end
        WRITE: begin
          mem_we_r     <= 1'b0;
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
        default: begin
          mem_we_r     <= 1'b0;
          resp_valid_r <= 1'b0;
          req_ready_r  <= 1'b1;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_rdata = resp_rdata_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a small word memory model: a vector table of
// single accesses plus handshake and reset-during-RMW sequences.
module tb_lsu_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   wr_count;

  lsu_ctrl_if #(.ADDR_LEN(32), .DATA_LEN(32)) bus ();

  lsu_ctrl #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:63];

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

  // Memory model: writes on the rising edge that ends a mem_we cycle
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  lat;
    logic [3:0]  nw;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rd, output logic er,
                         output int lat, output int nw);
    int w0;
    @(negedge clk);
    w0 = wr_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    rd  = 32'h0;
    er  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = k;
        rd  = bus.resp_rdata;
        er  = bus.resp_err;
        break;
      end
    end
    nw = wr_count - w0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nw;
  int          w0;
  logic        seen;

  initial begin
    total = 0;
    bad   = 0;
    wr_count = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4]  = 32'h0000_0000;
    mem[5]  = 32'h5555_5555;
    mem[8]  = 32'h80F1_7F00;
    mem[9]  = 32'h7777_7777;
    mem[17] = 32'hA5A5_A5A5;
    mem[18] = 32'hA5A5_A5A5;
    mem[19] = 32'hA5A5_A5A5;

    //             we    f3      addr         wdata          rdata          err   lat   nw    word
    vecs[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 4'd2, 4'd1, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 4'd2, 4'd0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 3'b000, 32'h11, 32'h0000_00AA, 32'h0000_0000, 1'b0, 4'd3, 4'd1, 32'hDEAD_AAEF};
    vecs[3]  = '{1'b0, 3'b010, 32'h10, 32'h0000_0000, 32'hDEAD_AAEF, 1'b0, 4'd2, 4'd0, 32'hDEAD_AAEF};
    vecs[4]  = '{1'b0, 3'b000, 32'h21, 32'h0000_0000, 32'h0000_007F, 1'b0, 4'd2, 4'd0, 32'h80F1_7F00};
    vecs[5]  = '{1'b0, 3'b000, 32'h22, 32'h0000_0000, 32'hFFFF_FFF1, 1'b0, 4'd2, 4'd0, 32'h80F1_7F00};
    vecs[6]  = '{1'b0, 3'b100, 32'h23, 32'h0000_0000, 32'h0000_0080, 1'b0, 4'd2, 4'd0, 32'h80F1_7F00};
    vecs[7]  = '{1'b0, 3'b001, 32'h22, 32'h0000_0000, 32'hFFFF_80F1, 1'b0, 4'd2, 4'd0, 32'h80F1_7F00};
    vecs[8]  = '{1'b0, 3'b101, 32'h22, 32'h0000_0000, 32'h0000_80F1, 1'b0, 4'd2, 4'd0, 32'h80F1_7F00};
    vecs[9]  = '{1'b0, 3'b010, 32'h13, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'd1, 4'd0, 32'hDEAD_AAEF};
    vecs[10] = '{1'b1, 3'b001, 32'h15, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 4'd1, 4'd0, 32'h5555_5555};
    vecs[11] = '{1'b0, 3'b011, 32'h20, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'd1, 4'd0, 32'h80F1_7F00};
    vecs[12] = '{1'b1, 3'b011, 32'h20, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd1, 4'd0, 32'h80F1_7F00};
    vecs[13] = '{1'b0, 3'b001, 32'h21, 32'h0000_0000, 32'h0000_0000, 1'b1, 4'd1, 4'd0, 32'h80F1_7F00};
    vecs[14] = '{1'b1, 3'b001, 32'h22, 32'h0000_1234, 32'h0000_0000, 1'b0, 4'd3, 4'd1, 32'h1234_7F00};
    vecs[15] = '{1'b0, 3'b010, 32'h20, 32'h0000_0000, 32'h1234_7F00, 1'b0, 4'd2, 4'd0, 32'h1234_7F00};
    vecs[16] = '{1'b0, 3'b101, 32'h20, 32'h0000_0000, 32'h0000_7F00, 1'b0, 4'd2, 4'd0, 32'h1234_7F00};
    vecs[17] = '{1'b0, 3'b000, 32'h20, 32'h0000_0000, 32'h0000_0000, 1'b0, 4'd2, 4'd0, 32'h1234_7F00};

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat, nw);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].err});
      check($sformatf("v%0d_latency", i), lat, {28'h0, vecs[i].lat});
      check($sformatf("v%0d_writes", i), nw, {28'h0, vecs[i].nw});
      check($sformatf("v%0d_memword", i), mem[vecs[i].addr[7:2]], vecs[i].word);
    end

    // Handshake: req_valid held high with changing address while an SH is busy
    @(negedge clk);
    w0 = wr_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b001;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h0000_BEEF;
    @(posedge clk);
    #1;
    bus.req_addr  = 32'h44;
    bus.req_wdata = 32'h0000_1111;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check($sformatf("hs_ready_c%0d", k), {31'h0, bus.req_ready}, 32'h0);
      check($sformatf("hs_resp_valid_c%0d", k), {31'h0, bus.resp_valid}, (k == 3) ? 32'h1 : 32'h0);
      @(posedge clk);
      #1;
      if (k < 3) begin
        bus.req_addr = 32'h44 + 32'(4 * k);
      end else begin
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h20;
      end
    end
    @(negedge clk);
    check("hs_ready_after_resp", {31'h0, bus.req_ready}, 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("hs_lw_c1_valid", {31'h0, bus.resp_valid}, 32'h0);
    @(negedge clk);
    check("hs_lw_c2_valid", {31'h0, bus.resp_valid}, 32'h1);
    check("hs_lw_rdata", bus.resp_rdata, 32'h1234_BEEF);
    check("hs_writes", wr_count - w0, 32'd1);
    check("hs_mem_44", mem[17], 32'hA5A5_A5A5);
    check("hs_mem_48", mem[18], 32'hA5A5_A5A5);
    check("hs_mem_4c", mem[19], 32'hA5A5_A5A5);

    // Reset asserted in the WRITE cycle of an SB
    @(negedge clk);
    w0 = wr_count;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h24;
    bus.req_wdata  = 32'h0000_0012;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rr_write_cycle_we", {31'h0, bus.mem_we}, 32'h1);
    rst = 1'b1;
    #1;
    check("rr_mem_we", {31'h0, bus.mem_we}, 32'h0);
    check("rr_req_ready", {31'h0, bus.req_ready}, 32'h1);
    check("rr_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
    check("rr_resp_err", {31'h0, bus.resp_err}, 32'h0);
    check("rr_mem_addr", bus.mem_addr, 32'h0);
    check("rr_mem_wdata", bus.mem_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1'b1;
    end
    check("rr_no_resp", {31'h0, seen}, 32'h0);
    check("rr_writes", wr_count - w0, 32'd0);
    check("rr_mem_word", mem[9], 32'h7777_7777);

    run_req(1'b0, 3'b010, 32'h24, 32'h0, rd, er, lat, nw);
    check("post_rst_lw_rdata", rd, 32'h7777_7777);
    check("post_rst_lw_latency", lat, 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
